// File: rtl/instr_sequencer_pkg.sv
// Shared types and field layout for the instruction sequencer.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   localparam int INSTR_W     = 9;
   localparam int PROG_W      = 10;

   localparam int SEL_IN_LSB  = 0;
   localparam int SEL_OUT_LSB = 3;
   localparam int OP_LSB      = 6;
   localparam int FIELD_W     = 3;

   localparam int LAST_BIT    = 9;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write port, asynchronous read port.
module seq_prog_mem
   import seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [PROG_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [PROG_W-1:0] rdata
);

   logic [PROG_W-1:0] mem_q [DEPTH];

   // contents survive reset, so no reset branch here
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through the program memory and presents each instruction to the
// decoder for a programmable number of cycles. All outputs are registered
// one cycle behind the FSM state, so the instruction bus, strobe, busy and
// done all line up with each other.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int HW    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [PROG_W-1:0]  load_data,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic [HW-1:0]      hold_cycles,
   output logic [INSTR_W-1:0] instruct,
   output logic               instr_valid,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      pc
);

   seq_state_t         state_q;
   logic [AW-1:0]      pc_q;
   logic [AW-1:0]      pc_out_q;
   logic [HW-1:0]      hold_q;
   logic [HW-1:0]      cnt_q;
   logic [INSTR_W-1:0] instr_q;
   logic               vld_q;
   logic               busy_q;
   logic               done_q;

   logic [PROG_W-1:0]  word;
   logic               mem_we;
   seq_state_t         adv_state_d;
   logic [AW-1:0]      adv_pc_d;

   // the program may only be rewritten while nothing is executing
   assign mem_we = load_en && (state_q == IDLE || state_q == DONE);

   seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc_q),
      .rdata (word)
   );

   // where execution goes once the current word has been held long enough;
   // loop_en is looked at here, at the moment of advancing
   always_comb begin
      adv_state_d = ISSUE;
      adv_pc_d    = pc_q + 1'b1;
      if (word[LAST_BIT] || pc_q == AW'(DEPTH - 1)) begin
         if (loop_en) begin
            adv_pc_d = '0;
         end else begin
            adv_state_d = DONE;
            adv_pc_d    = pc_q;
         end
      end
   end

   // sequencer FSM with its counter, pc and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         pc_out_q <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         instr_q  <= '0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         vld_q  <= 1'b0;
         busy_q <= (state_q == ISSUE) || (state_q == HOLD);
         done_q <= (state_q == DONE);
         case (state_q)
            IDLE, DONE: begin
               if (start && !stop) begin
                  state_q <= ISSUE;
                  pc_q    <= '0;
                  hold_q  <= hold_cycles;
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               if (stop) begin
                  state_q <= IDLE;
                  instr_q <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  instr_q  <= word[INSTR_W-1:0];
                  pc_out_q <= pc_q;
                  vld_q    <= 1'b1;
                  cnt_q    <= hold_q;
                  if (hold_q != '0) begin
                     state_q <= HOLD;
                  end else begin
                     state_q <= adv_state_d;
                     pc_q    <= adv_pc_d;
                  end
               end
            end
            HOLD: begin
               if (stop) begin
                  state_q <= IDLE;
                  instr_q <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == HW'(1)) begin
                     state_q <= adv_state_d;
                     pc_q    <= adv_pc_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instruct    = instr_q;
   assign instr_valid = vld_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pc          = pc_out_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer. The reference model expands the
// program into the expected per-cycle bus trace (H+1 cycles per word, then
// a done cycle) and every output sample is compared against it.
module tb_instr_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int HW    = 4;
   localparam logic [31:0] NO_PC = 32'hFFFF_E1FF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [9:0]    load_data = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          loop_en = 1'b0;
   logic [HW-1:0] hold_cycles = '0;
   logic [8:0]    instruct;
   logic          instr_valid;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;

   int n_cmp = 0;
   int n_err = 0;
   int run_id = 0;

   logic [9:0] mem_m [DEPTH];

   typedef struct {
      logic [8:0]    ins;
      logic [AW-1:0] pc;
      logic          v;
      logic          b;
      logic          d;
   } exp_t;

   exp_t tq[$];

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HW(HW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .hold_cycles (hold_cycles),
      .instruct    (instruct),
      .instr_valid (instr_valid),
      .busy        (busy),
      .done        (done),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {16'h0, done, busy, instr_valid, pc, instruct};
   endfunction

   function automatic logic [31:0] epack(input exp_t e);
      return {16'h0, e.d, e.b, e.v, e.pc, e.ins};
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [9:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
      mem_m[a]  = d;
   endtask

   // expand the program into the expected output trace
   task automatic build(input int h, input bit lp, input int passes, output int fstart);
      logic [AW-1:0] a;
      bit fin;
      int np;
      exp_t e;
      tq.delete();
      fstart = 0;
      np = lp ? passes : 1;
      for (int p = 0; p < np; p++) begin
         a = '0;
         fin = 1'b0;
         fstart = tq.size();
         while (!fin) begin
            for (int c = 0; c <= h; c++) begin
               e.ins = mem_m[a][8:0];
               e.pc  = a;
               e.v   = (c == 0);
               e.b   = 1'b1;
               e.d   = 1'b0;
               tq.push_back(e);
            end
            if (mem_m[a][9] || a == AW'(DEPTH - 1)) fin = 1'b1;
            else a = a + 1'b1;
         end
      end
      e = tq[tq.size() - 1];
      e.v = 1'b0;
      e.b = 1'b0;
      e.d = 1'b1;
      tq.push_back(e);
   endtask

   // stop_sel: -1 none, -2 random point, >=0 that trace index
   task automatic run(input int h, input bit lp, input int passes, input int stop_sel, input bit bad_wr);
      int fs;
      int nb;
      int stop_at;
      build(h, lp, passes, fs);
      nb = tq.size() - 1;
      stop_at = -1;
      if (stop_sel >= 0 && stop_sel < nb - 1) stop_at = stop_sel;
      else if (stop_sel == -2 && nb > 2) stop_at = int'($urandom_range(nb - 2, 0));
      run_id++;
      hold_cycles = HW'(h);
      loop_en = lp;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("r%0d lat", run_id), {30'h0, busy, instr_valid}, 32'h0);
      for (int j = 0; j < tq.size(); j++) begin
         @(negedge clk);
         load_en = 1'b0;
         chk($sformatf("r%0d c%0d", run_id, j), obs(), epack(tq[j]));
         if (j == stop_at) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            chk($sformatf("r%0d stop", run_id), obs() & NO_PC, 32'h0);
            @(negedge clk);
            chk($sformatf("r%0d stop2", run_id), obs() & NO_PC, 32'h0);
            return;
         end
         if (lp && j == fs) loop_en = 1'b0;
         if (bad_wr && j == 1 && nb > 2) begin
            load_en   = 1'b1;
            load_addr = AW'($urandom);
            load_data = 10'($urandom);
         end
      end
      @(negedge clk);
      chk($sformatf("r%0d idle", run_id), {29'h0, done, busy, instr_valid}, 32'h0);
   endtask

   initial begin
      int len;
      int h;
      repeat (2) @(negedge clk);
      chk("reset", obs(), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic three-word program, H=6 then H=0
      wr(0, 10'h1F4);
      wr(1, 10'h124);
      wr(2, 10'h2DC);
      run(6, 1'b0, 1, -1, 1'b0);
      run(0, 1'b0, 1, -1, 1'b0);

      // stop wins over start in the same cycle
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      chk("stop_pri", {30'h0, busy, instr_valid}, 32'h0);

      // abort in the third hold cycle with a blocked write, then re-run
      run(6, 1'b0, 1, 3, 1'b1);
      run(2, 1'b0, 1, -1, 1'b0);

      // two-word loop, dropped during the third pass
      wr(0, 10'h0AB);
      wr(1, 10'h255);
      run(1, 1'b1, 3, -1, 1'b0);

      // asynchronous reset in the middle of a hold
      hold_cycles = 4'd6;
      loop_en = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst", obs(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run(6, 1'b0, 1, -1, 1'b0);

      // full depth, no LAST flag anywhere
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), {1'b0, 9'($urandom)});
      run(1, 1'b0, 1, -1, 1'b0);

      // random programs, holds, looping, aborts and blocked writes
      for (int r = 0; r < 12; r++) begin
         len = int'($urandom_range(DEPTH, 1));
         for (int i = 0; i < DEPTH; i++) wr(AW'(i), {(i == len - 1), 9'($urandom)});
         h = ($urandom % 5 == 0) ? 15 : int'($urandom_range(3, 0));
         run(h, ($urandom % 3 == 0), int'($urandom_range(3, 2)),
             ($urandom % 3 == 0) ? -2 : -1, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: bench did not complete within its time limit");
      $fatal(1);
   end

endmodule
